// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared constants, state encoding and helpers for the USB
// serial-to-parallel receiver (sipo_rx) and its shift sub-block.
//   SIPO_W          - deserialized word width (USB bytes only)
//   SYNC_BYTE       - SYNC value after LSB-first reassembly
//   DEF_MAX_BYTES   - default payload byte limit after the PID
//   DEF_COUNT_WIDTH - default byte counter width (must hold the limit)
//   PID_*           - PID[3:0] nibble codes
//   rx_state_t      - receiver state encoding
//   pid_check()     - PID integrity check (low nibble vs inverted high nibble)
package sipo_rx_pkg;

  localparam int         SIPO_W          = 8;
  localparam logic [7:0] SYNC_BYTE       = 8'hC1;
  localparam int         DEF_MAX_BYTES   = 64;
  localparam int         DEF_COUNT_WIDTH = 7;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [1:0] {
    RX_HUNT    = 2'd0,
    RX_PID     = 2'd1,
    RX_DATA    = 2'd2,
    RX_DISCARD = 2'd3
  } rx_state_t;

  // A PID byte is valid when its upper nibble is the bitwise complement of the lower one.
  function automatic logic pid_check(input logic [7:0] pid_byte);
    return (pid_byte[3:0] == ~pid_byte[7:4]);
  endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// sipo_rx_if: serial input stream and parallel output stream of the receiver.
//   sipo_data_in / sipo_data_val / sipo_data_last - decoded serial bits from the line decoder
//   sipo_data_out / sipo_data_out_val / sipo_data_out_last - payload bytes to the RX FIFO
// Modports:
//   master - the environment (drives bits, consumes bytes)
//   slave  - the receiver (consumes bits, produces bytes)
interface sipo_rx_if
  import sipo_rx_pkg::*;
#(
  parameter int W = SIPO_W
);

  logic         sipo_data_in;
  logic         sipo_data_val;
  logic         sipo_data_last;
  logic [W-1:0] sipo_data_out;
  logic         sipo_data_out_val;
  logic         sipo_data_out_last;

  modport master (
    output sipo_data_in, sipo_data_val, sipo_data_last,
    input  sipo_data_out, sipo_data_out_val, sipo_data_out_last
  );

  modport slave (
    input  sipo_data_in, sipo_data_val, sipo_data_last,
    output sipo_data_out, sipo_data_out_val, sipo_data_out_last
  );

endinterface

// File: rtl/sipo_rx_shift.sv
// sipo_rx_shift: LSB-first shift register plus in-byte bit counter.
//   clk, rst     - clock, synchronous active-high reset
//   bit_in       - serial bit
//   bit_val      - qualifies bit_in
//   shreg_clear  - on a qualified bit, clear the window instead of shifting
//   cnt_clear    - on a qualified bit, restart the bit counter at 0
//   next_byte    - window value including the current bit (post-shift view)
//   byte_done    - current qualified bit is the 8th bit of a byte
module sipo_rx_shift
  import sipo_rx_pkg::*;
#(
  parameter int W = SIPO_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         bit_val,
  input  logic         shreg_clear,
  input  logic         cnt_clear,
  output logic [W-1:0] next_byte,
  output logic         byte_done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  shreg;
  logic [CW-1:0] bit_cnt;

  // New bits enter at the top so the first bit of a byte ends up in bit 0.
  assign next_byte = {bit_in, shreg[W-1:1]};
  assign byte_done = bit_val && (bit_cnt == CW'(W - 1));

  // Shift window and bit counter, advancing only on qualified bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= {W{1'b0}};
      bit_cnt <= {CW{1'b0}};
    end else if (bit_val) begin
      shreg   <= shreg_clear ? {W{1'b0}} : next_byte;
      bit_cnt <= cnt_clear ? {CW{1'b0}} : (bit_cnt + CW'(1));
    end else begin
      shreg   <= shreg;
      bit_cnt <= bit_cnt;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: USB receive deserializer. Hunts for SYNC in the LSB-first bit
// stream, checks the PID byte, then emits payload bytes to the RX FIFO.
//   clk, rst           - clock, synchronous active-high reset
//   bus (slave)        - serial input and parallel byte output (sipo_rx_if)
//   pid_out            - last accepted PID[3:0]
//   pid_val / pid_err  - one-cycle pulses: PID accepted / PID bad or cut short
//   sync_detected      - one-cycle pulse on SYNC match
//   frame_err          - one-cycle pulse on partial byte at EOP or overlength
//   rx_active          - high from SYNC match until the packet ends
//   byte_count         - payload bytes delivered in the current or last packet
// All outputs are registered and appear the cycle after the deciding bit.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int         SIPO_DATA_WIDTH = SIPO_W,
  parameter logic [7:0] SYNC_PATTERN    = SYNC_BYTE,
  parameter int         MAX_BYTES       = DEF_MAX_BYTES,
  parameter int         COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  sipo_rx_if.slave               bus,
  output logic [3:0]             pid_out,
  output logic                   pid_val,
  output logic                   pid_err,
  output logic                   sync_detected,
  output logic                   frame_err,
  output logic                   rx_active,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  rx_state_t                  state;
  logic [SIPO_DATA_WIDTH-1:0] next_byte;
  logic                       byte_done;
  logic                       bit_val;
  logic                       bit_last;
  logic                       sync_hit;
  logic                       shreg_clear;
  logic                       cnt_clear;
  logic [SIPO_DATA_WIDTH-1:0] out_byte;
  logic                       out_val;
  logic                       out_last;

  assign bit_val  = bus.sipo_data_val;
  assign bit_last = bus.sipo_data_val && bus.sipo_data_last;

  assign bus.sipo_data_out      = out_byte;
  assign bus.sipo_data_out_val  = out_val;
  assign bus.sipo_data_out_last = out_last;

  // SYNC match on the post-shift window; an end-of-packet bit never starts a packet.
  // Every packet end wipes the window so stale tail bits cannot fake a SYNC.
  always_comb begin
    sync_hit    = 1'b0;
    shreg_clear = 1'b0;
    if ((state == RX_HUNT) && bit_val && !bus.sipo_data_last &&
        (next_byte == SYNC_PATTERN)) begin
      sync_hit = 1'b1;
    end else begin
      sync_hit = 1'b0;
    end
    if (bit_last) begin
      shreg_clear = 1'b1;
    end else begin
      shreg_clear = 1'b0;
    end
    cnt_clear = sync_hit || shreg_clear;
  end

  sipo_rx_shift #(
    .W(SIPO_DATA_WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bus.sipo_data_in),
    .bit_val    (bit_val),
    .shreg_clear(shreg_clear),
    .cnt_clear  (cnt_clear),
    .next_byte  (next_byte),
    .byte_done  (byte_done)
  );

  // Receiver FSM with registered status, pulse and byte outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_HUNT;
      pid_out       <= 4'd0;
      pid_val       <= 1'b0;
      pid_err       <= 1'b0;
      sync_detected <= 1'b0;
      frame_err     <= 1'b0;
      rx_active     <= 1'b0;
      byte_count    <= {COUNT_WIDTH{1'b0}};
      out_byte      <= {SIPO_DATA_WIDTH{1'b0}};
      out_val       <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      pid_val       <= 1'b0;
      pid_err       <= 1'b0;
      sync_detected <= 1'b0;
      frame_err     <= 1'b0;
      out_val       <= 1'b0;
      out_last      <= 1'b0;
      if (bit_val) begin
        case (state)
          RX_HUNT: begin
            if (sync_hit) begin
              sync_detected <= 1'b1;
              rx_active     <= 1'b1;
              byte_count    <= {COUNT_WIDTH{1'b0}};
              state         <= RX_PID;
            end
          end
          RX_PID: begin
            if (byte_done) begin
              if (pid_check(next_byte[7:0])) begin
                pid_out    <= next_byte[3:0];
                pid_val    <= 1'b1;
                byte_count <= {COUNT_WIDTH{1'b0}};
                // Last on the PID byte itself is a handshake packet.
                if (bit_last) begin
                  rx_active <= 1'b0;
                  state     <= RX_HUNT;
                end else begin
                  state <= RX_DATA;
                end
              end else begin
                pid_err <= 1'b1;
                if (bit_last) begin
                  rx_active <= 1'b0;
                  state     <= RX_HUNT;
                end else begin
                  state <= RX_DISCARD;
                end
              end
            end else if (bit_last) begin
              pid_err   <= 1'b1;
              rx_active <= 1'b0;
              state     <= RX_HUNT;
            end
          end
          RX_DATA: begin
            if (byte_done) begin
              if (byte_count == COUNT_WIDTH'(MAX_BYTES)) begin
                // Overlength byte is dropped; if it is also the last bit there is nothing left to discard.
                frame_err <= 1'b1;
                if (bit_last) begin
                  rx_active <= 1'b0;
                  state     <= RX_HUNT;
                end else begin
                  state <= RX_DISCARD;
                end
              end else begin
                out_byte   <= next_byte;
                out_val    <= 1'b1;
                out_last   <= bit_last;
                byte_count <= byte_count + COUNT_WIDTH'(1);
                if (bit_last) begin
                  rx_active <= 1'b0;
                  state     <= RX_HUNT;
                end
              end
            end else if (bit_last) begin
              frame_err <= 1'b1;
              rx_active <= 1'b0;
              state     <= RX_HUNT;
            end
          end
          RX_DISCARD: begin
            if (bit_last) begin
              rx_active <= 1'b0;
              state     <= RX_HUNT;
            end
          end
          default: begin
            rx_active <= 1'b0;
            state     <= RX_HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx. Two receivers share one bit stream: one
// with the default payload limit and one limited to 4 bytes. A packet-level
// model turns each packet description into the list of expected output
// events (kind, value, deciding bit) which the monitor matches pulse by pulse.
module tb_sipo_rx;
  import sipo_rx_pkg::*;

  localparam int K_SYNC = 0;
  localparam int K_PIDV = 1;
  localparam int K_PIDE = 2;
  localparam int K_DATA = 3;
  localparam int K_FERR = 4;

  typedef struct {
    int kind;
    int val;
    int g;
  } evt_t;

  typedef struct {
    string       name;
    logic [79:0] body;
    int          nbits;
    int          bc0;
    int          bc1;
    int          nd0;
    int          nd1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dval = 1'b0;
  logic dlast = 1'b0;
  int   cyc = 0;

  int   total = 0;
  int   bad = 0;
  int   bit_cyc[$];
  evt_t q0[$];
  evt_t q1[$];
  int   ndata[2];
  int   mbc[2];
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sipo_rx_if #(.W(8)) bus0 ();
  sipo_rx_if #(.W(8)) bus1 ();
  assign bus0.sipo_data_in   = din;
  assign bus0.sipo_data_val  = dval;
  assign bus0.sipo_data_last = dlast;
  assign bus1.sipo_data_in   = din;
  assign bus1.sipo_data_val  = dval;
  assign bus1.sipo_data_last = dlast;

  wire [1:0]      sync_det, pid_v, pid_e, ferr, rxa;
  wire [1:0][3:0] pid_o;
  wire [1:0][6:0] bcnt;

  sipo_rx dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .pid_out(pid_o[0]), .pid_val(pid_v[0]), .pid_err(pid_e[0]),
    .sync_detected(sync_det[0]), .frame_err(ferr[0]),
    .rx_active(rxa[0]), .byte_count(bcnt[0])
  );

  sipo_rx #(.MAX_BYTES(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .pid_out(pid_o[1]), .pid_val(pid_v[1]), .pid_err(pid_e[1]),
    .sync_detected(sync_det[1]), .frame_err(ferr[1]),
    .rx_active(rxa[1]), .byte_count(bcnt[1])
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input int d, input int k, input int v, input int g);
    evt_t e;
    e.kind = k;
    e.val  = v;
    e.g    = g;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic evt_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    else        return q1.pop_front();
  endfunction

  // Expected events of one packet: SYNC ends at bit base-1, body starts at base.
  function automatic void model(input int d, input logic [79:0] body, input int nbits,
                                input bit has_last, input int base, input int maxb,
                                output int bc);
    logic [7:0] pid;
    int full, rem, l;
    bc = 0;
    push(d, K_SYNC, 0, base - 1);
    if (nbits < 8) begin
      if (has_last) push(d, K_PIDE, 0, base + nbits - 1);
      return;
    end
    pid = body[7:0];
    if (pid[3:0] != ~pid[7:4]) begin
      push(d, K_PIDE, 0, base + 7);
      return;
    end
    push(d, K_PIDV, int'(pid[3:0]), base + 7);
    full = (nbits - 8) / 8;
    rem  = (nbits - 8) % 8;
    for (int j = 0; j < full; j++) begin
      if (j >= maxb) begin
        push(d, K_FERR, 0, base + 15 + 8 * j);
        return;
      end
      l = (has_last && rem == 0 && j == full - 1) ? 1 : 0;
      push(d, K_DATA, l * 256 + int'(body[8 * (j + 1) +: 8]), base + 15 + 8 * j);
      bc = j + 1;
    end
    if (has_last && rem != 0) push(d, K_FERR, 0, base + nbits - 1);
  endfunction

  function automatic void check_evt(input int d, input int k, input int v);
    evt_t e;
    int   want_cyc;
    total++;
    if (qsize(d) == 0) begin
      bad++;
      $display("FAIL dut%0d unexpected event: got kind=%0d val=%0h cyc=%0d want none", d, k, v, cyc);
      return;
    end
    e = qpop(d);
    want_cyc = (e.g < bit_cyc.size()) ? bit_cyc[e.g] : -1;
    if (e.kind != k || e.val != v || want_cyc != cyc) begin
      bad++;
      $display("FAIL dut%0d event: got kind=%0d val=%0h cyc=%0d want kind=%0d val=%0h cyc=%0d",
               d, k, v, cyc, e.kind, e.val, want_cyc);
    end
  endfunction

  function automatic void mon(input int d, input logic sd, input logic pv, input logic pe,
                              input logic fe, input logic dv, input logic dl,
                              input logic [3:0] pid, input logic [7:0] dout);
    if (sd) check_evt(d, K_SYNC, 0);
    if (pv) check_evt(d, K_PIDV, int'(pid));
    if (pe) check_evt(d, K_PIDE, 0);
    if (fe) check_evt(d, K_FERR, 0);
    if (dv) begin
      ndata[d]++;
      check_evt(d, K_DATA, (dl ? 256 : 0) + int'(dout));
    end
    if (dl && !dv) begin
      total++;
      bad++;
      $display("FAIL dut%0d data_last: got last=1 val=0 want last=0", d);
    end
  endfunction

  always @(negedge clk) begin
    mon(0, sync_det[0], pid_v[0], pid_e[0], ferr[0], bus0.sipo_data_out_val,
        bus0.sipo_data_out_last, pid_o[0], bus0.sipo_data_out);
    mon(1, sync_det[1], pid_v[1], pid_e[1], ferr[1], bus1.sipo_data_out_val,
        bus1.sipo_data_out_last, pid_o[1], bus1.sipo_data_out);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      dval  = 1'b0;
      din   = 1'($urandom_range(0, 1));
      dlast = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_bit(input logic b, input logic l, input int gapmax);
    if (gapmax > 0) idle($urandom_range(0, gapmax));
    @(posedge clk);
    #1;
    din   = b;
    dval  = 1'b1;
    dlast = l;
    bit_cyc.push_back(cyc + 1);
  endtask

  task automatic send_pkt(input logic [79:0] body, input int nbits, input bit has_last,
                          input int gapmax);
    logic [7:0] syn;
    int base;
    syn  = SYNC_BYTE;
    base = bit_cyc.size() + 8;
    model(0, body, nbits, has_last, base, 64, mbc[0]);
    model(1, body, nbits, has_last, base, 4, mbc[1]);
    ndata[0] = 0;
    ndata[1] = 0;
    for (int i = 0; i < 8; i++) drive_bit(syn[i], 1'b0, gapmax);
    for (int i = 0; i < nbits; i++) drive_bit(body[i], has_last && (i == nbits - 1), gapmax);
    idle(3);
  endtask

  task automatic end_chk(input string name, input int d, input int exp_bc, input int exp_nd);
    chk($sformatf("%s rx_active dut%0d", name, d), rxa[d], 0);
    chk($sformatf("%s byte_count dut%0d", name, d), bcnt[d], exp_bc);
    chk($sformatf("%s data_pulses dut%0d", name, d), ndata[d], exp_nd);
    chk($sformatf("%s pending_events dut%0d", name, d), qsize(d), 0);
  endtask

  task automatic check_zero(input string name);
    chk(name, {sync_det, pid_v, pid_e, ferr, rxa, pid_o, bcnt,
               bus0.sipo_data_out, bus0.sipo_data_out_val, bus0.sipo_data_out_last,
               bus1.sipo_data_out, bus1.sipo_data_out_val, bus1.sipo_data_out_last}, 0);
  endtask

  initial begin
    logic [79:0] rb;
    logic [3:0]  nib;
    int          nb, r;
    logic [3:0]  goods[4];

    goods[0] = PID_ACK;
    goods[1] = PID_NAK;
    goods[2] = PID_DATA0;
    goods[3] = PID_DATA1;

    tbl[0] = '{"ack",      {72'h0, 8'hD2}, 8, 0, 0, 0, 0};
    tbl[1] = '{"data0_2b", {56'h0, 8'h3C, 8'hA5, 8'hC3}, 24, 2, 2, 2, 2};
    tbl[2] = '{"bad_pid",  {56'h0, 16'h1234, 8'hD3}, 24, 0, 0, 0, 0};
    tbl[3] = '{"after_bad", {64'h0, 8'h00, 8'h4B}, 16, 1, 1, 1, 1};
    tbl[4] = '{"partial",  {59'h0, 5'b10110, 8'hFF, 8'hC3}, 21, 1, 1, 1, 1};
    tbl[5] = '{"short_pid", {72'h0, 8'h16}, 5, 0, 0, 0, 0};
    tbl[6] = '{"nak",      {72'h0, 8'h5A}, 8, 0, 0, 0, 0};
    tbl[7] = '{"overlen",  {24'h0, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hC3},
               56, 6, 4, 6, 4};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("post_reset");

    for (int i = 0; i < 8; i++) begin
      send_pkt(tbl[i].body, tbl[i].nbits, 1'b1, 0);
      end_chk(tbl[i].name, 0, tbl[i].bc0, tbl[i].nd0);
      end_chk(tbl[i].name, 1, tbl[i].bc1, tbl[i].nd1);
    end

    // Same DATA0 packet with random idle gaps between bits.
    send_pkt(tbl[1].body, tbl[1].nbits, 1'b1, 3);
    end_chk("gapped", 0, 2, 2);
    end_chk("gapped", 1, 2, 2);

    // Reset after 12 payload bits: packet is abandoned, outputs clear.
    send_pkt(tbl[1].body, 20, 1'b0, 2);
    chk("active_before_rst", rxa, 2'b11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_cycle");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("after_rst");
    chk("rst_pending0", qsize(0), 0);
    chk("rst_pending1", qsize(1), 0);
    send_pkt(tbl[1].body, tbl[1].nbits, 1'b1, 1);
    end_chk("post_rst_pkt", 0, 2, 2);
    end_chk("post_rst_pkt", 1, 2, 2);

    // Random packets against the packet-level model.
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < 10; k++) rb[k * 8 +: 8] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        nib = goods[$urandom_range(0, 3)];
        rb[7:0] = {~nib, nib};
      end
      r = $urandom_range(0, 9);
      if (r == 0) nb = $urandom_range(1, 7);
      else nb = 8 + 8 * $urandom_range(0, 7) + ((r == 1) ? $urandom_range(1, 7) : 0);
      send_pkt(rb, nb, 1'b1, 3);
      end_chk($sformatf("rand%0d", p), 0, mbc[0], ndata[0] >= 0 ? mbc[0] : -1);
      end_chk($sformatf("rand%0d", p), 1, mbc[1], mbc[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Receive-side counterpart of the hub's parallel-to-serial transmitter.
- Takes the decoded serial bit stream (LSB first, one bit per qualified cycle) and hunts for the SYNC byte.
- Captures and checks the PID byte, then deserializes the payload bytes into parallel words.
- Sits between the line decoder and the transaction receiver; parallel bytes go to the receive FIFO write port.

Parameters:
- SIPO_DATA_WIDTH, 8, width of each deserialized word. Only 8 is supported for USB.
- SYNC_PATTERN, 8'hC1, SYNC byte value after LSB-first reassembly (wire order 1,0,0,0,0,0,1,1).
- MAX_BYTES, 64, maximum payload bytes after the PID. Exceeding it is a frame error.
- COUNT_WIDTH, 7, width of the byte counter. Must hold MAX_BYTES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sipo_data_in  input  1  serial data bit
- sipo_data_val  input  1  qualifies sipo_data_in this cycle
- sipo_data_last  input  1  marks the last bit of the packet; only honoured when sipo_data_val=1
- sipo_data_out  output  SIPO_DATA_WIDTH  assembled payload byte
- sipo_data_out_val  output  1  one-cycle pulse, sipo_data_out valid (FIFO write enable)
- sipo_data_out_last  output  1  with sipo_data_out_val, marks the final payload byte
- pid_out  output  4  received PID[3:0]
- pid_val  output  1  one-cycle pulse, PID byte captured and check passed
- pid_err  output  1  one-cycle pulse, PID check failed or PID byte incomplete
- sync_detected  output  1  one-cycle pulse on SYNC match
- frame_err  output  1  one-cycle pulse on a partial byte at EOP or on overlength
- rx_active  output  1  high from SYNC match until the packet ends
- byte_count  output  COUNT_WIDTH  payload bytes delivered in the current or last packet

Behaviour:
- Reset (synchronous, active-high clk/rst as decided):
  - All outputs are 0; the shift register, bit counter and byte_count are cleared; state is HUNT.
  - Reset asserted mid-packet aborts the packet immediately. No pulses are emitted in the reset cycle or the cycle after.
- Shift register: on each qualified bit, shreg <= {sipo_data_in, shreg[7:1]}. The first bit received lands in bit 0.
- Bit counter: 3 bits, counts qualified bits within the current byte, and wraps 7->0 on byte completion.
- Latency: every output pulse is registered. It appears the cycle after the qualified bit that completes the byte.
- State machine:
  - HUNT:
    - Slide the window on every qualified bit; the bit counter is not used.
    - When the post-shift value equals SYNC_PATTERN: pulse sync_detected, set rx_active, clear the bit counter, go to PID.
    - sipo_data_last in HUNT clears shreg and stays in HUNT, with no error.
  - PID:
    - After 8 bits, if byte[3:0] == ~byte[7:4]: pid_out <= byte[3:0], pulse pid_val, clear byte_count, go to DATA. Otherwise pulse pid_err and go to DISCARD.
    - If sipo_data_last arrives before the 8th bit: pulse pid_err, drop rx_active, go to HUNT.
    - sipo_data_last on exactly the 8th bit with a good PID (handshake packet, e.g. ACK 8'hD2): pulse pid_val, drop rx_active, go to HUNT.
  - DATA, on each completed byte:
    - Drive sipo_data_out, pulse sipo_data_out_val, increment byte_count.
    - If sipo_data_last is on that bit: also assert sipo_data_out_last, drop rx_active, go to HUNT.
    - If sipo_data_last arrives with the bit counter not at 7: no byte is output, pulse frame_err, go to HUNT. byte_count keeps its value.
    - A byte completing while byte_count == MAX_BYTES: not output, pulse frame_err, go to DISCARD.
  - DISCARD: ignore bits until a qualified sipo_data_last, then drop rx_active and go to HUNT.
- sipo_data_val low: hold all state; no pulses.
- No backpressure: one word per at least 8 cycles. The downstream FIFO must accept every sipo_data_out_val; overflow handling belongs to the FIFO.
- byte_count saturates at MAX_BYTES. It holds after packet end until the next SYNC match.

Decomposition:
- Shared package/defines header:
  - SYNC value 8'hC1.
  - PID nibble constants (ACK 4'b0010, NAK 4'b1010, DATA0 4'b0011, DATA1 4'b1011).
  - rx state encoding (HUNT, PID, DATA, DISCARD).
  - Range macro usage is consistent with the transmitter.
- One natural sub-module, sipo_shift: the shift register plus bit counter, with a byte_done strobe. The FSM stays in sipo_rx.

Test Plan:
1. SYNC bits 1,0,0,0,0,0,1,1 then ACK 8'hD2 LSB first, last on bit 16 -> sync_detected one cycle after bit 8, pid_val with pid_out=4'b0010 after bit 16, no sipo_data_out_val, rx_active low afterwards.
2. SYNC, PID 8'hC3 (DATA0), bytes 8'hA5, 8'h3C, last on bit 32 -> two sipo_data_out_val pulses (A5, then 3C with sipo_data_out_last=1), byte_count=2.
3. SYNC then PID 8'hD3 (check fails) then 16 bits and last -> pid_err pulse, no data pulses, return to HUNT; a following good packet is received normally.
4. SYNC, PID 8'hC3, 8'hFF, then 5 bits with last on the 5th -> one data pulse (FF), then frame_err, byte_count=1.
5. Random valid gaps (val low 0-3 cycles) during case 2 -> identical outputs; rst raised after 12 payload bits -> all outputs 0, and the next SYNC is detected cleanly.
6. MAX_BYTES=4 with 6 payload bytes -> 4 data pulses, frame_err on the 5th byte, nothing further until last, byte_count=4.
